router_cfg_regfile: RTL

Parametrised configuration register file for the router; replaces the fixed three-channel, write-only register set. It holds NUM_CH channel-address registers and a CRC-enable control bit behind a valid/ready config port. Writes land in shadow registers and reach the active outputs only through an explicit commit, applied atomically while the router datapath is idle. Optional registered readback. Sits between the config master and the channel demux and CRC logic.

---
 rtl/router_cfg_regfile_if.sv | 24 ++
 rtl/router_cfg_regfile.sv | 106 ++++++++++
 2 files changed

// File: rtl/router_cfg_regfile_if.sv
// Config bus between the config master and router_cfg_regfile.
// Carries the valid/ready request and the registered read return.
interface router_cfg_regfile_if #(
   parameter int CFG_ADDR_W = 4,
   parameter int CFG_DATA_W = 8
) ();
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic                  cfg_we;
   logic [CFG_ADDR_W-1:0] cfg_addr;
   logic [CFG_DATA_W-1:0] cfg_wdata;
   logic                  cfg_rvalid;
   logic [CFG_DATA_W-1:0] cfg_rdata;

   modport master (
      output cfg_valid, cfg_we, cfg_addr, cfg_wdata,
      input  cfg_ready, cfg_rvalid, cfg_rdata
   );

   modport slave (
      input  cfg_valid, cfg_we, cfg_addr, cfg_wdata,
      output cfg_ready, cfg_rvalid, cfg_rdata
   );
endinterface

// File: rtl/router_cfg_regfile.sv
// Router config register file: shadow channel/CRC registers, committed atomically while the router is idle.
// Optional registered readback is built only when CFG_READBACK_EN is defined.
module router_cfg_regfile #(
   parameter int NUM_CH     = 3,
   parameter int CH_ADDR_W  = 2,
   parameter int CFG_ADDR_W = 4,
   parameter int CFG_DATA_W = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   router_cfg_regfile_if.slave           cfg,
   input  logic                          router_busy,
   output logic [NUM_CH*CH_ADDR_W-1:0]   ch_addr,
   output logic                          crc_en,
   output logic                          cfg_pending,
   output logic                          cfg_applied
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PENDING = 2'd1;
   localparam logic [1:0] ST_APPLY   = 2'd2;

   localparam logic [CFG_ADDR_W-1:0] CTRL_ADDR   = CFG_ADDR_W'(NUM_CH);
   localparam logic [CFG_ADDR_W-1:0] COMMIT_ADDR = CFG_ADDR_W'(NUM_CH + 1);

   logic [1:0]           state;
   logic [CH_ADDR_W-1:0] sh_ch [NUM_CH];
   logic                 sh_crc;
   logic                 accept;
   logic                 wr_en;
   logic                 commit_req;
   logic                 apply_now;
   logic                 unused_wdata;

   assign cfg.cfg_ready = (state == ST_IDLE);
   assign accept        = cfg.cfg_valid && cfg.cfg_ready;
   assign wr_en         = accept && cfg.cfg_we;
   assign commit_req    = wr_en && (cfg.cfg_addr == COMMIT_ADDR);
   assign apply_now     = (state == ST_PENDING) && !router_busy;
   assign cfg_pending   = (state == ST_PENDING);
   assign cfg_applied   = (state == ST_APPLY);
   assign unused_wdata  = ^cfg.cfg_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (commit_req) state <= ST_PENDING;
            ST_PENDING: if (!router_busy) state <= ST_APPLY;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   // Shadow writes only happen in IDLE since cfg_ready gates acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) sh_ch[i] <= '0;
         sh_crc <= 1'b0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_addr == CFG_ADDR_W'(i)) sh_ch[i] <= cfg.cfg_wdata[CH_ADDR_W-1:0];
         end
         if (cfg.cfg_addr == CTRL_ADDR) sh_crc <= cfg.cfg_wdata[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_addr <= '0;
         crc_en  <= 1'b0;
      end else if (apply_now) begin
         for (int i = 0; i < NUM_CH; i++) ch_addr[i*CH_ADDR_W +: CH_ADDR_W] <= sh_ch[i];
         crc_en <= sh_crc;
      end
   end

`ifdef CFG_READBACK_EN
   logic [CFG_DATA_W-1:0] rd_mux;

   // Reads return shadow contents; unmapped addresses fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg.cfg_addr == CFG_ADDR_W'(i)) rd_mux[CH_ADDR_W-1:0] = sh_ch[i];
      end
      if (cfg.cfg_addr == CTRL_ADDR)   rd_mux[0] = sh_crc;
      if (cfg.cfg_addr == COMMIT_ADDR) rd_mux[0] = cfg_pending;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg.cfg_rvalid <= 1'b0;
         cfg.cfg_rdata  <= '0;
      end else begin
         cfg.cfg_rvalid <= accept && !cfg.cfg_we;
         if (accept && !cfg.cfg_we) cfg.cfg_rdata <= rd_mux;
      end
   end
`else
   assign cfg.cfg_rvalid = 1'b0;
   assign cfg.cfg_rdata  = '0;
`endif

endmodule
